// File: rtl/frase_parser.sv
// Sentence grammar checker with an 8-word buffer. The grammar is
// substantivo adjetivo* verbo (substantivo adjetivo*)?, and accepted sentences are played back to a downstream consumer.
module frase_parser (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Word_valid,
    input  logic [1:0] Tipo,
    input  logic       End,
    output logic       Word_ready,
    output logic       Sentence_ok,
    output logic       Sentence_err,
    output logic [3:0] Word_count,
    output logic       Out_valid,
    output logic [1:0] Out_tipo,
    input  logic       Out_ready
);

    typedef enum logic [2:0] {IDLE, SUBJ, VERB, OBJ, ERR, PLAY} state_t;

    localparam logic [1:0] T_SUBST = 2'b11;
    localparam logic [1:0] T_VERBO = 2'b10;
    localparam logic [1:0] T_ADJ   = 2'b01;

    state_t     state;
    state_t     word_state;
    logic [1:0] buffer [8];
    logic [2:0] rd;
    logic       end_cond;
    logic       accept;
    logic       enter_err;
    logic       write_en;
    logic       last_word;
    logic [3:0] count_after_word;

    // word_state is the state after the current word alone, so End can be judged against it
    always_comb begin
        end_cond   = End || (Word_valid && (Tipo == 2'b00));
        accept     = Word_valid && Word_ready && (Tipo != 2'b00);
        word_state = state;
        if (accept) begin
            case (state)
                IDLE:    word_state = (Tipo == T_SUBST) ? SUBJ : ERR;
                SUBJ: begin
                    if (Tipo == T_ADJ)
                        word_state = SUBJ;
                    else if (Tipo == T_VERBO)
                        word_state = VERB;
                    else
                        word_state = ERR;
                end
                VERB:    word_state = (Tipo == T_SUBST) ? OBJ : ERR;
                OBJ:     word_state = (Tipo == T_ADJ) ? OBJ : ERR;
                default: word_state = state;
            endcase
            if ((state != ERR) && (Word_count == 4'd8))
                word_state = ERR;
        end
        enter_err        = accept && (state != ERR) && (word_state == ERR);
        write_en         = accept && (state != ERR) && (word_state != ERR);
        count_after_word = enter_err ? '0 : (write_en ? Word_count + 4'd1 : Word_count);
        last_word        = ({1'b0, rd} == (Word_count - 4'd1));
    end

    always_ff @(posedge clk) begin
        if (write_en && !Reset)
            buffer[Word_count[2:0]] <= Tipo;
    end

    always_ff @(posedge clk) begin
        if (Reset) begin
            state        <= IDLE;
            Word_count   <= '0;
            rd           <= '0;
            Word_ready   <= 1'b1;
            Sentence_ok  <= 1'b0;
            Sentence_err <= 1'b0;
            Out_valid    <= 1'b0;
            Out_tipo     <= '0;
        end else begin
            Sentence_ok  <= 1'b0;
            Sentence_err <= 1'b0;
            if (state == PLAY) begin
                if (Out_ready) begin
                    if (last_word) begin
                        state      <= IDLE;
                        Word_count <= '0;
                        rd         <= '0;
                        Out_valid  <= 1'b0;
                        Out_tipo   <= '0;
                        Word_ready <= 1'b1;
                    end else begin
                        rd       <= rd + 3'd1;
                        Out_tipo <= buffer[rd + 3'd1];
                    end
                end
            end else begin
                Sentence_err <= enter_err;
                state        <= word_state;
                Word_count   <= count_after_word;
                if (end_cond) begin
                    case (word_state)
                        VERB, OBJ: begin
                            // buffer[0] is never written on this edge: a complete sentence has >= 2 words
                            state       <= PLAY;
                            Sentence_ok <= 1'b1;
                            Out_valid   <= 1'b1;
                            Out_tipo    <= buffer[0];
                            rd          <= '0;
                            Word_ready  <= 1'b0;
                        end
                        SUBJ: begin
                            state        <= IDLE;
                            Sentence_err <= 1'b1;
                            Word_count   <= '0;
                        end
                        default: begin
                            state      <= IDLE;
                            Word_count <= '0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: doc/frase_parser.md
FRASE_PARSER -- requirements
Module: frase_parser

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all logic on rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port Word_valid, input, 1 bit: upstream word strobe; the upstream classifier drives it.
REQ-004 SHALL have port Tipo, input, 2 bits: word class (11 = substantivo, 10 = verbo, 01 = adjetivo, 00 = end marker).
REQ-005 SHALL have port End, input, 1 bit: upstream end-of-sentence pulse.
REQ-006 SHALL have port Word_ready, output, 1 bit: high when the block accepts a word.
REQ-007 SHALL have port Sentence_ok, output, 1 bit: one-cycle pulse when a sentence is accepted.
REQ-008 SHALL have port Sentence_err, output, 1 bit: one-cycle pulse when a sentence is rejected.
REQ-009 SHALL have port Word_count, output, 4 bits: number of words buffered in the current sentence.
REQ-010 SHALL have port Out_valid, output, 1 bit: playback word valid.
REQ-011 SHALL have port Out_tipo, output, 2 bits: playback word class.
REQ-012 SHALL have port Out_ready, input, 1 bit: downstream accepts a playback word.

Function
REQ-013 SHALL accept a word only on a cycle with Word_valid=1, Word_ready=1, and Tipo!=00; the word is written to buffer[Word_count], and Word_count is incremented on the next edge.
REQ-014 SHALL provide an 8-entry x 2-bit buffer; accepting a 9th word SHALL be an overflow error.
REQ-015 SHALL implement FSM states IDLE, SUBJ, VERB, OBJ, ERR, PLAY.
REQ-016 SHALL drive Word_ready=1 in IDLE, SUBJ, VERB, OBJ, and ERR, and Word_ready=0 in PLAY.
REQ-017 SHALL implement the grammar substantivo adjetivo* verbo (substantivo adjetivo*)?, as transitions on an accepted word:
- IDLE: 11 -> SUBJ; any other class -> ERR.
- SUBJ: 01 -> SUBJ; 10 -> VERB; 11 -> ERR.
- VERB: 11 -> OBJ; other -> ERR.
- OBJ: 01 -> OBJ; other -> ERR.
REQ-018 SHALL treat the end condition as End=1, or Word_valid=1 with Tipo=00; both forms are equivalent.
REQ-019 SHALL, when a word accept and End occur in the same cycle, process the word first and evaluate End against the resulting state in that same edge.
REQ-020 SHALL, on the end condition in VERB or OBJ (after REQ-019), pulse Sentence_ok on the next cycle and enter PLAY.
REQ-021 SHALL, on the end condition in SUBJ, pulse Sentence_err on the next cycle, clear Word_count to 0, and enter IDLE.
REQ-022 SHALL ignore the end condition in IDLE with Word_count=0: no pulse, stay in IDLE.
REQ-023 SHALL, on entry to ERR (grammar violation or overflow), pulse Sentence_err once and clear Word_count to 0.
REQ-024 SHALL, in ERR, accept and discard words without writing the buffer, and return to IDLE on the end condition with no further pulse.
REQ-025 SHALL, in PLAY, drive Out_valid=1 with Out_tipo=buffer[rd], rd starting at 0.
REQ-026 SHALL, in PLAY, increment rd on each cycle with Out_valid=1 and Out_ready=1.
REQ-027 SHALL hold Out_tipo stable while Out_valid=1 and Out_ready=0.
REQ-028 SHALL, after the handshake of word Word_count-1, deassert Out_valid, clear Word_count and rd, and enter IDLE on that same edge.
REQ-029 SHALL drive Out_valid=0 and Out_tipo=00 outside PLAY.
REQ-030 SHALL never assert Sentence_ok and Sentence_err in the same cycle.

Reset
REQ-031 SHALL, on Reset=1 at a clock edge, set state=IDLE, Word_count=0, rd=0, Word_ready=1, Sentence_ok=0, Sentence_err=0, Out_valid=0, Out_tipo=00; buffer contents don't-care.
REQ-032 SHALL let Reset override all other inputs, including mid-sentence and mid-PLAY; no pulse SHALL be generated by reset.

Verification
REQ-033 SHALL be covered by bench scenario: words 11, 01, 10 then End -> Sentence_ok pulse 1 cycle later, Word_count=3, then playback 11, 01, 10 with Out_ready=1, then IDLE with Word_count=0.
REQ-034 SHALL be covered by bench scenario: words 11, 10, 11, 01 with Tipo=00 as the end marker, Out_ready held 0 for 3 cycles -> Out_tipo=11 held stable, then playback of 4 words.
REQ-035 SHALL be covered by bench scenario: words 10 first -> Sentence_err pulse, ERR state, further words discarded, End -> IDLE, with no Sentence_ok.
REQ-036 SHALL be covered by bench scenario: words 11, 01 x7, then an 11 (9th word) -> overflow, Sentence_err, Word_count=0.
REQ-037 SHALL be covered by bench scenario: word 10 accepted with End in the same cycle after 11 -> Sentence_ok; and 11 alone then End -> Sentence_err.
REQ-038 SHALL be covered by bench scenario: Reset asserted during PLAY after 1 of 3 words -> Out_valid=0, IDLE, Word_count=0 next cycle, with no pulses.
